sobel_frame_sequencer: RTL

SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

---
 rtl/sobel_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_sequencer.sv
// Sobel frame sequencer: walks interior pixels, gathers 3x3 neighbours,
// feeds two conv units, squares and sums their results, writes magnitude.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a frame (taken only in IDLE/DONE)
//   rd_en/rd_addr     : pixel read strobe/address, rd_data one cycle later
//   valid_data        : one-cycle operand strobe to both conv units
//   in_*_x / in_*_y   : registered X/Y conv operands
//   conv_ready_x/y    : conv result valid, edge_data_in_x/y signed results
//   sqrt_num/sqrt_sq  : operand to / result from combinational sqrt
//   wr_en/wr_addr/wr_data : magnitude write port
//   busy, done        : frame in progress / frame complete
module sobel_frame_sequencer #(
  parameter int data_size          = 24,
  parameter int conv_out_data_size = 29,
  parameter int sqrt_in_data_size  = 60,
  parameter int sqrt_out_data_size = sqrt_in_data_size / 2,
  parameter int img_w              = 8,
  parameter int img_h              = 8,
  parameter int addr_width         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          rd_en,
  output logic [addr_width-1:0]         rd_addr,
  input  logic [data_size-1:0]          rd_data,
  output logic                          valid_data,
  output logic [data_size-1:0]          in_p1a_x,
  output logic [data_size-1:0]          in_p2_x,
  output logic [data_size-1:0]          in_p1b_x,
  output logic [data_size-1:0]          in_m1a_x,
  output logic [data_size-1:0]          in_m2_x,
  output logic [data_size-1:0]          in_m1b_x,
  output logic [data_size-1:0]          in_p1a_y,
  output logic [data_size-1:0]          in_p2_y,
  output logic [data_size-1:0]          in_p1b_y,
  output logic [data_size-1:0]          in_m1a_y,
  output logic [data_size-1:0]          in_m2_y,
  output logic [data_size-1:0]          in_m1b_y,
  input  logic                          conv_ready_x,
  input  logic                          conv_ready_y,
  input  logic [conv_out_data_size-1:0] edge_data_in_x,
  input  logic [conv_out_data_size-1:0] edge_data_in_y,
  output logic [sqrt_in_data_size-1:0]  sqrt_num,
  input  logic [sqrt_out_data_size-1:0] sqrt_sq,
  output logic                          wr_en,
  output logic [addr_width-1:0]         wr_addr,
  output logic [sqrt_out_data_size-1:0] wr_data,
  output logic                          busy,
  output logic                          done
);

  localparam logic [addr_width-1:0] W =
    addr_width'(img_w);
  localparam logic [addr_width-1:0] LAST_C =
    addr_width'(img_w - 2);
  localparam logic [addr_width-1:0] LAST_R =
    addr_width'(img_h - 2);
  localparam logic [addr_width-1:0] ONE =
    addr_width'(1);
  localparam int SX =
    sqrt_in_data_size - conv_out_data_size;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_CONV,
    SQRT,
    CAPT,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [addr_width-1:0] row;
  logic [addr_width-1:0] col;
  logic [3:0]            fcnt;
  logic                  fx;
  logic                  fy;

  logic [conv_out_data_size-1:0] ex;
  logic [conv_out_data_size-1:0] ey;

  logic signed [sqrt_in_data_size-1:0] xs;
  logic signed [sqrt_in_data_size-1:0] ys;
  logic [sqrt_in_data_size-1:0]        mag;

  logic [1:0]            dr;
  logic [1:0]            dc;
  logic [addr_width-1:0] dr_e;
  logic [addr_width-1:0] dc_e;

  logic last_col;
  logic last_pix;
  logic idle_like;
  logic both_rdy;

  assign last_col  = (col == LAST_C);
  assign last_pix  = last_col && (row == LAST_R);
  assign idle_like = (state == IDLE) ||
                     (state == DONE);
  assign both_rdy  = (fx || conv_ready_x) &&
                     (fy || conv_ready_y);

  assign rd_en      = (state == FETCH) &&
                      (fcnt < 4'd8);
  assign valid_data = (state == ISSUE);
  assign wr_en      = (state == WRITE);
  assign busy       = !idle_like;
  assign done       = (state == DONE);

  assign wr_addr = wr_en ? row * W + col : '0;

  // Squares are taken on sign-extended values so the sum is exact.
  assign xs  = {{SX{ex[conv_out_data_size-1]}}, ex};
  assign ys  = {{SX{ey[conv_out_data_size-1]}}, ey};
  assign mag = xs * xs + ys * ys;

  // Neighbour offsets (0..2 meaning -1..+1) for each fetch slot;
  // the centre pixel is skipped.
  always_comb begin
    dr = 2'd1;
    dc = 2'd1;
    case (fcnt)
      4'd0: begin dr = 2'd0; dc = 2'd0; end
      4'd1: begin dr = 2'd0; dc = 2'd1; end
      4'd2: begin dr = 2'd0; dc = 2'd2; end
      4'd3: begin dr = 2'd1; dc = 2'd0; end
      4'd4: begin dr = 2'd1; dc = 2'd2; end
      4'd5: begin dr = 2'd2; dc = 2'd0; end
      4'd6: begin dr = 2'd2; dc = 2'd1; end
      4'd7: begin dr = 2'd2; dc = 2'd2; end
      default: begin dr = 2'd1; dc = 2'd1; end
    endcase
  end

  assign dr_e = {{(addr_width-2){1'b0}}, dr};
  assign dc_e = {{(addr_width-2){1'b0}}, dc};

  always_comb begin
    rd_addr = '0;
    if (rd_en) begin
      rd_addr = (row + dr_e - ONE) * W +
                col + dc_e - ONE;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (start) state_nx = FETCH;
      FETCH:     if (fcnt == 4'd8) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_CONV;
      WAIT_CONV: if (both_rdy) state_nx = SQRT;
      SQRT:      state_nx = CAPT;
      CAPT:      state_nx = WRITE;
      WRITE:     state_nx = last_pix ? DONE : FETCH;
      DONE:      if (start) state_nx = FETCH;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row      <= '0;
      col      <= '0;
      fcnt     <= '0;
      fx       <= 1'b0;
      fy       <= 1'b0;
      ex       <= '0;
      ey       <= '0;
      sqrt_num <= '0;
      wr_data  <= '0;
      in_p1a_x <= '0;
      in_p2_x  <= '0;
      in_p1b_x <= '0;
      in_m1a_x <= '0;
      in_m2_x  <= '0;
      in_m1b_x <= '0;
      in_p1a_y <= '0;
      in_p2_y  <= '0;
      in_p1b_y <= '0;
      in_m1a_y <= '0;
      in_m2_y  <= '0;
      in_m1b_y <= '0;
    end else begin
      if (idle_like && start) begin
        row  <= ONE;
        col  <= ONE;
        fcnt <= '0;
      end
      if (state == FETCH) begin
        fcnt <= (fcnt == 4'd8) ? 4'd0 : fcnt + 4'd1;
        // Slot k holds the pixel read in slot k-1; each
        // neighbour goes straight to the operands it feeds.
        case (fcnt)
          4'd1: begin
            in_m1a_x <= rd_data;
            in_m1a_y <= rd_data;
          end
          4'd2: in_m2_y <= rd_data;
          4'd3: begin
            in_p1a_x <= rd_data;
            in_m1b_y <= rd_data;
          end
          4'd4: in_m2_x <= rd_data;
          4'd5: in_p2_x <= rd_data;
          4'd6: begin
            in_m1b_x <= rd_data;
            in_p1a_y <= rd_data;
          end
          4'd7: in_p2_y <= rd_data;
          4'd8: begin
            in_p1b_x <= rd_data;
            in_p1b_y <= rd_data;
          end
          default: ;
        endcase
      end
      if (state == ISSUE) begin
        fx <= 1'b0;
        fy <= 1'b0;
      end
      // Flags are sticky: the first ready per unit wins, so
      // skewed or simultaneous readies give one result.
      if (state == WAIT_CONV) begin
        if (conv_ready_x && !fx) begin
          fx <= 1'b1;
          ex <= edge_data_in_x;
        end
        if (conv_ready_y && !fy) begin
          fy <= 1'b1;
          ey <= edge_data_in_y;
        end
      end
      if (state == SQRT) begin
        sqrt_num <= mag;
      end
      if (state == CAPT) begin
        wr_data <= sqrt_sq;
      end
      if (state == WRITE) begin
        if (last_col) begin
          col <= ONE;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end
    end
  end

endmodule
